// File: rtl/obstacle_pkg.sv
// Shared types and constants for the dino-game obstacle spawn scheduler.
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    SELECT = 2'd2,
    ISSUE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KIND_SMALL_CACTUS = 2'd0,
    KIND_LARGE_CACTUS = 2'd1,
    KIND_CACTUS_GROUP = 2'd2,
    KIND_BIRD         = 2'd3
  } kind_e;

  localparam int DEFAULT_MIN_GAP = 40;
  localparam int COUNT_W         = 8;
  localparam int GAP_W           = 9;

  // Frames to wait before the next spawn; the random MSB is deliberately dropped.
  function automatic logic [GAP_W-1:0] gap_load(input int min_gap, input logic [8:0] rnd);
    return GAP_W'(min_gap) + {1'b0, rnd[7:0]};
  endfunction

endpackage

// File: rtl/rr_slot_picker.sv
// Combinational round-robin search for the first free obstacle slot after last_slot.
module rr_slot_picker #(
  parameter int NUM_SLOTS = 4,
  parameter int SW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic [SW-1:0]        last_slot,
  output logic                 found,
  output logic [SW-1:0]        slot
);

  logic [SW-1:0] idx;
  logic          hit;
  int            sum;

  // Walk offsets 1..NUM_SLOTS so last_slot itself is checked last.
  always_comb begin
    found = 1'b0;
    slot  = '0;
    idx   = '0;
    hit   = 1'b0;
    sum   = 0;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      sum   = int'(last_slot) + k;
      idx   = SW'((sum >= NUM_SLOTS) ? (sum - NUM_SLOTS) : sum);
      hit   = !found && !slot_busy[idx];
      slot  = hit ? idx : slot;
      found = found | hit;
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn sequencer: random frame gap, round-robin slot allocation, valid/ready issue.
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int MIN_GAP   = DEFAULT_MIN_GAP,
  parameter int SW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 run,
  input  logic [8:0]           rand_val,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic                 spawn_ready,
  output logic                 spawn_valid,
  output logic [SW-1:0]        spawn_slot,
  output logic [1:0]           spawn_kind,
  output logic [COUNT_W-1:0]   spawn_count
);

  state_e           state_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [SW-1:0]    last_slot_r;
  logic             pick_found_s;
  logic [SW-1:0]    pick_slot_s;
  logic             rand_unused;

  assign rand_unused = rand_val[8];

  rr_slot_picker #(
    .NUM_SLOTS(NUM_SLOTS),
    .SW       (SW)
  ) u_picker (
    .slot_busy(slot_busy),
    .last_slot(last_slot_r),
    .found    (pick_found_s),
    .slot     (pick_slot_s)
  );

  // Scheduler FSM, gap counter and spawn handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      gap_cnt_r   <= '0;
      last_slot_r <= SW'(NUM_SLOTS - 1);
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      spawn_kind  <= 2'd0;
      spawn_count <= '0;
    end else if (!run) begin
      // Pause or game over abandons any pending spawn without counting it.
      state_r     <= IDLE;
      gap_cnt_r   <= '0;
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      spawn_kind  <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r   <= GAP;
          gap_cnt_r <= gap_load(MIN_GAP, rand_val);
        end
        GAP: begin
          if (frame_tick) begin
            gap_cnt_r <= gap_cnt_r - 9'd1;
            if (gap_cnt_r == 9'd1) begin
              state_r <= SELECT;
            end else begin
              state_r <= GAP;
            end
          end else begin
            state_r <= GAP;
          end
        end
        SELECT: begin
          if (pick_found_s) begin
            state_r     <= ISSUE;
            spawn_valid <= 1'b1;
            spawn_slot  <= pick_slot_s;
            spawn_kind  <= rand_val[1:0];
          end else begin
            state_r <= SELECT;
          end
        end
        ISSUE: begin
          if (spawn_valid && spawn_ready) begin
            state_r     <= GAP;
            spawn_valid <= 1'b0;
            last_slot_r <= spawn_slot;
            spawn_count <= spawn_count + 8'd1;
            gap_cnt_r   <= gap_load(MIN_GAP, rand_val);
          end else begin
            state_r <= ISSUE;
          end
        end
        default: begin
          state_r     <= IDLE;
          spawn_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
